// File: rtl/ps2_log_pkg.sv
// Shared formatter state type, ASCII constants and PS/2 prefix codes for ps2_hex_logger.
// Defining PS2_LOG_EVENT_NEWLINE_EN adds the CR/LF formatter states.
package ps2_log_pkg;

`ifdef PS2_LOG_EVENT_NEWLINE_EN
    typedef enum logic [2:0] {
        FMT_IDLE, FMT_LOAD, FMT_HI, FMT_LO, FMT_SEP, FMT_CR, FMT_LF
    } fmt_state_t;
`else
    typedef enum logic [2:0] {
        FMT_IDLE, FMT_LOAD, FMT_HI, FMT_LO, FMT_SEP
    } fmt_state_t;
`endif

    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;

    localparam logic [7:0] CODE_E0 = 8'hE0;
    localparam logic [7:0] CODE_E1 = 8'hE1;
    localparam logic [7:0] CODE_F0 = 8'hF0;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
        if (nibble < 4'd10)
            return ASCII_ZERO + {4'd0, nibble};
        else
            return ASCII_UPPER_A + {4'd0, nibble - 4'd10};
    endfunction

    // Prefix bytes are part of a longer key event, so they never end a line.
    function automatic logic is_prefix(input logic [7:0] code);
        return (code == CODE_E0) || (code == CODE_E1) || (code == CODE_F0);
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter. busy drops during the last stop-bit cycle so a start
// issued then begins the next start bit with no idle gap.
module uart_tx_byte #(
    parameter int CLK_HZ = 25000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       start,
    output logic       busy,
    output logic       tx
);

    localparam int BIT_CYCLES = CLK_HZ / BAUD;
    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam logic [CW-1:0] BIT_RELOAD = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] bit_cnt;
    logic [3:0]    bit_idx;
    logic [8:0]    shift;
    logic          active;
    logic          last_cycle;

    assign last_cycle = active && (bit_idx == 4'd9) && (bit_cnt == '0);
    assign busy       = active && !last_cycle;

    // bit_idx 0 is the start bit, 1..8 data LSB first, 9 the stop bit
    always_ff @(posedge clk) begin
        if (reset) begin
            active  <= 1'b0;
            tx      <= 1'b1;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '1;
        end else if (start && !busy) begin
            active  <= 1'b1;
            tx      <= 1'b0;
            shift   <= {1'b1, data};
            bit_idx <= '0;
            bit_cnt <= BIT_RELOAD;
        end else if (active) begin
            if (bit_cnt == '0) begin
                if (bit_idx == 4'd9) begin
                    active <= 1'b0;
                    tx     <= 1'b1;
                end else begin
                    tx      <= shift[0];
                    shift   <= {1'b1, shift[8:1]};
                    bit_idx <= bit_idx + 1'b1;
                    bit_cnt <= BIT_RELOAD;
                end
            end else begin
                bit_cnt <= bit_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_hex_logger.sv
// Logs PS/2 scancodes as uppercase ASCII hex plus separator over a UART.
// Define PS2_LOG_EVENT_NEWLINE_EN to end each non-prefix code with CR LF.
//
// state | meaning
// IDLE  | waiting for FIFO data
// LOAD  | pop code into hold, hand upper-nibble digit (taken from FIFO head)
// HI    | upper digit on line, hand lower-nibble digit
// LO    | lower digit on line, hand separator
// SEP   | separator on line; newline build hands CR unless code was a prefix
// CR    | CR on line, hand LF (newline build only)
// LF    | LF on line, return to idle (newline build only)
module ps2_hex_logger
    import ps2_log_pkg::*;
#(
    parameter int         CLK_HZ = 25000000,
    parameter int         BAUD   = 115200,
    parameter int         DEPTH  = 16,
    parameter logic [7:0] SEP    = 8'h20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               key_data,
    input  logic                     key_valid,
    input  logic                     key_error,
    output logic                     uart_tx,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [7:0]               err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [7:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    fmt_state_t state;
    fmt_state_t state_nxt;
    logic [3:0] hold_lo;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_ready;

    assign fifo_full  = (fifo_level == FULL_LEVEL);
    assign fifo_empty = (fifo_level == '0);
    assign push       = key_valid && !fifo_full;
    assign fifo_head  = fifo_mem[rd_ptr];
    assign tx_ready   = !tx_busy;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= key_data;
    end

    // A full FIFO drops the incoming code even when a pop frees a slot this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fifo_level <= fifo_level + 1'b1;
            else if (pop && !push)
                fifo_level <= fifo_level - 1'b1;
            if (key_valid && fifo_full)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            err_count <= '0;
        else if (key_error && (err_count != 8'hFF))
            err_count <= err_count + 1'b1;
    end

`ifdef PS2_LOG_EVENT_NEWLINE_EN
    logic hold_prefix;

    always_ff @(posedge clk) begin
        if (reset)
            hold_prefix <= 1'b0;
        else if (pop)
            hold_prefix <= is_prefix(fifo_head);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset)
            hold_lo <= '0;
        else if (pop)
            hold_lo <= fifo_head[3:0];
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= FMT_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FMT_IDLE: if (!fifo_empty) state_nxt = FMT_LOAD;
            FMT_LOAD: if (tx_ready)    state_nxt = FMT_HI;
            FMT_HI:   if (tx_ready)    state_nxt = FMT_LO;
            FMT_LO:   if (tx_ready)    state_nxt = FMT_SEP;
`ifdef PS2_LOG_EVENT_NEWLINE_EN
            FMT_SEP: begin
                if (hold_prefix)
                    state_nxt = FMT_IDLE;
                else if (tx_ready)
                    state_nxt = FMT_CR;
            end
            FMT_CR:   if (tx_ready)    state_nxt = FMT_LF;
            FMT_LF:                    state_nxt = FMT_IDLE;
`else
            FMT_SEP:                   state_nxt = FMT_IDLE;
`endif
            default:                   state_nxt = FMT_IDLE;
        endcase
    end

    always_comb begin
        tx_start = 1'b0;
        tx_data  = 8'h00;
        pop      = 1'b0;
        case (state)
            FMT_LOAD: begin
                tx_data  = hex_ascii(fifo_head[7:4]);
                tx_start = tx_ready;
                pop      = tx_ready;
            end
            FMT_HI: begin
                tx_data  = hex_ascii(hold_lo);
                tx_start = tx_ready;
            end
            FMT_LO: begin
                tx_data  = SEP;
                tx_start = tx_ready;
            end
`ifdef PS2_LOG_EVENT_NEWLINE_EN
            FMT_SEP: begin
                tx_data  = ASCII_CR;
                tx_start = tx_ready && !hold_prefix;
            end
            FMT_CR: begin
                tx_data  = ASCII_LF;
                tx_start = tx_ready;
            end
`endif
            default: ;
        endcase
    end

    uart_tx_byte #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_uart_tx_byte (
        .clk   (clk),
        .reset (reset),
        .data  (tx_data),
        .start (tx_start),
        .busy  (tx_busy),
        .tx    (uart_tx)
    );

endmodule

// File: tb/tb_ps2_hex_logger.sv
// Scoreboard bench for ps2_hex_logger: directed key strobes push expected UART
// bytes into a queue; a UART monitor decodes the line and pops/compares.
module tb_ps2_hex_logger;

    localparam int BIT   = 217;   // 25_000_000 / 115_200
    localparam int HALF  = 108;
    localparam int FRAME = 2170;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] key_data = 8'h00;
    logic       key_valid = 1'b0;
    logic       key_error = 1'b0;
    logic       uart_tx;
    logic [2:0] fifo_level;
    logic       overflow;
    logic [7:0] err_count;

    ps2_hex_logger #(
        .CLK_HZ (25000000),
        .BAUD   (115200),
        .DEPTH  (4),
        .SEP    (8'h20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_data   (key_data),
        .key_valid  (key_valid),
        .key_error  (key_error),
        .uart_tx    (uart_tx),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    longint     starts[$];
    bit         mon_busy = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = 8'h00;
    longint     low_cnt = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic exp_code(input logic [7:0] hi, input logic [7:0] lo, input bit ends_line);
        exp_q.push_back(hi);
        exp_q.push_back(lo);
        exp_q.push_back(8'h20);
`ifdef PS2_LOG_EVENT_NEWLINE_EN
        if (ends_line) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
`else
        if (ends_line) begin end
`endif
    endtask

    // UART monitor: samples mid-bit on the falling edge, aborts on reset
    always @(negedge clk) begin
        if (uart_tx === 1'b0)
            low_cnt++;
        if (reset) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (uart_tx === 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt  = 0;
                starts.push_back(cyc);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == HALF) begin
                check("start_bit", uart_tx, 0);
            end else if (mon_cnt > HALF && mon_cnt < HALF + 9*BIT && (mon_cnt - HALF) % BIT == 0) begin
                mon_byte[(mon_cnt - HALF) / BIT - 1] = uart_tx;
            end else if (mon_cnt == HALF + 9*BIT) begin
                check("stop_bit", uart_tx, 1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL uart_unexpected_byte: got 0x%0h, expected no byte", mon_byte);
                end else begin
                    check("uart_byte", mon_byte, exp_q.pop_front());
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic wait_drain(input int max_cycles, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        repeat (300) @(negedge clk);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t0;
        longint lc;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_err_count", err_count, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // single code 1C -> "1C ", latency and bit timing
        starts.delete();
        exp_code(8'h31, 8'h43, 1'b1);
        @(negedge clk);
        key_data  = 8'h1C;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        t0 = cyc;
        wait_drain(20000, "drain_1c");
        check("start_count_1c", (starts.size() >= 3) ? 1 : 0, 1);
        if (starts.size() >= 3) begin
            check("first_start_latency", starts[0] - t0, 2);
            check("frame_spacing_0", starts[1] - starts[0], FRAME);
            check("frame_spacing_1", starts[2] - starts[1], FRAME);
        end

        // prefix then code: "F0 1C " (+ CR LF after 1C only in newline build)
        exp_code(8'h46, 8'h30, 1'b0);
        exp_code(8'h31, 8'h43, 1'b1);
        @(negedge clk);
        key_data  = 8'hF0;
        key_valid = 1'b1;
        @(negedge clk);
        key_data  = 8'h1C;
        @(negedge clk);
        key_valid = 1'b0;
        wait_drain(30000, "drain_f0_1c");

        // DEPTH=4 overflow: six back-to-back codes, 06 dropped
        for (int i = 1; i <= 5; i++)
            exp_code(8'h30, 8'h30 + 8'(i), 1'b1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 4)
                check("level_push_pop_at_2", fifo_level, 2);
            if (i == 6) begin
                check("level_full", fifo_level, 4);
                check("overflow_before_drop", overflow, 0);
            end
            key_data  = 8'(i);
            key_valid = 1'b1;
        end
        @(negedge clk);
        key_valid = 1'b0;
        check("level_after_drop", fifo_level, 4);
        check("overflow_after_drop", overflow, 1);
        wait_drain(70000, "drain_depth");
        check("overflow_sticky", overflow, 1);

        // 300 error strobes: saturate at 255, nothing pushed or sent
        lc = low_cnt;
        @(negedge clk);
        key_error = 1'b1;
        repeat (254) @(negedge clk);
        check("err_count_254", err_count, 254);
        repeat (46) @(negedge clk);
        key_error = 1'b0;
        check("err_count_sat", err_count, 255);
        check("err_fifo_level", fifo_level, 0);
        repeat (20) @(negedge clk);
        check("err_line_idle", low_cnt - lc, 0);

        // reset in the middle of data bit 3 of 'A' (code AA), BB still queued
        @(negedge clk);
        key_data  = 8'hAA;
        key_valid = 1'b1;
        @(negedge clk);
        key_data  = 8'hBB;
        t0 = cyc;
        @(negedge clk);
        key_valid = 1'b0;
        while (cyc < t0 + 952)
            @(negedge clk);
        check("frame_in_progress", mon_busy, 1);
        check("level_before_reset", fifo_level, 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_uart_tx", uart_tx, 1);
        check("abort_fifo_level", fifo_level, 0);
        check("abort_overflow", overflow, 0);
        check("abort_err_count", err_count, 0);
        @(negedge clk);
        reset = 1'b0;
        lc = low_cnt;
        repeat (3000) @(negedge clk);
        check("no_resume_after_reset", low_cnt - lc, 0);
        check("level_after_reset", fifo_level, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
